// File: rtl/xge_channel_emu_if.sv
// xge_channel_emu_if: MAC-side word stream entering and leaving the channel emulator.
interface xge_channel_emu_if #(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 8
);
    logic [DATA_W-1:0] rxd_i;
    logic [CTRL_W-1:0] rxc_i;
    logic [DATA_W-1:0] txd_o;
    logic [CTRL_W-1:0] txc_o;

    // Stream endpoint (MAC model): drives ingress words, observes egress words.
    modport master (output rxd_i, output rxc_i, input txd_o, input txc_o);
    // Channel: consumes ingress words, produces delayed egress words.
    modport slave (input rxd_i, input rxc_i, output txd_o, output txc_o);
endinterface

// File: rtl/xge_channel_emu.sv
// xge_channel_emu: one direction of a PHY-side link with a run-time adjustable delay.
// Delay changes are applied only across an idle gap long enough that no frame word
// is dropped or repeated. Also provides link-down forcing and egress frame counting.
// Optional single-bit error injection is built when CHANNEL_ERR_INJ_EN is defined.
module xge_channel_emu #(
    parameter int          DATA_W     = 64,
    parameter int          CTRL_W     = 8,
    parameter int          ADDR_W     = 5,
    parameter int          MAX_DELAY  = 31,
    parameter int          INIT_DELAY = 8,
    parameter logic [63:0] IDLE_D     = 64'h0707070707070707,
    parameter logic [7:0]  IDLE_C     = 8'hFF
) (
    input  logic                clk,
    input  logic                rst,
    xge_channel_emu_if.slave    bus,
    input  logic [ADDR_W-1:0]   delay_i,
    input  logic                delay_wr_i,
    output logic [ADDR_W-1:0]   delay_o,
    output logic                delay_pend_o,
    input  logic                link_up_i,
    output logic [31:0]         frame_cnt_o,
    input  logic                err_inj_i,
    output logic                err_inj_done_o
);
    localparam int                 DEPTH     = 1 << ADDR_W;
    localparam int                 WORD_W    = CTRL_W + DATA_W;
    localparam logic [WORD_W-1:0]  IDLE_WORD = {IDLE_C[CTRL_W-1:0], IDLE_D[DATA_W-1:0]};
    localparam logic [ADDR_W-1:0]  MAX_D     = ADDR_W'(MAX_DELAY);
    localparam logic [ADDR_W-1:0]  INIT_D    = ADDR_W'(INIT_DELAY);

    logic [WORD_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_delay;
    logic [ADDR_W-1:0] r_pend_delay;
    logic              r_pend;
    logic [ADDR_W:0]   r_idle_run;
    logic [31:0]       r_frame_cnt;
    logic              r_prev_idle;

    logic [WORD_W-1:0] w_in_word;
    logic              w_in_idle;
    logic [ADDR_W-1:0] w_rd_addr;
    logic [WORD_W-1:0] w_link_word;
    logic              w_out_idle;
    logic              w_delay_ok;
    logic [ADDR_W-1:0] w_need;
    logic              w_apply;

    assign w_in_word  = {bus.rxc_i, bus.rxd_i};
    assign w_in_idle  = (w_in_word == IDLE_WORD);
    assign w_rd_addr  = r_wr_ptr - r_delay;
    assign w_out_idle = (w_link_word == IDLE_WORD);

    // A new delay is only safe once the idle gap covers both the old and new latency.
    assign w_delay_ok = delay_wr_i && (delay_i <= MAX_D);
    assign w_need     = (r_delay > r_pend_delay) ? r_delay : r_pend_delay;
    assign w_apply    = r_pend && (r_idle_run >= {1'b0, w_need});

    // Circular buffer: store every ingress word, advance the write pointer each cycle.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every register samples pre-edge values.
        if (rst) begin
            // NOTE: the buffer is cleared to idle so no pre-reset word can reach the output.
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= IDLE_WORD;
            end
            r_wr_ptr <= '0;
        end else begin
            r_mem[r_wr_ptr] <= w_in_word;
            r_wr_ptr        <= r_wr_ptr + ADDR_W'(1);
        end
    end

    // Count consecutive idle ingress words, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (rst || !w_in_idle) begin
            r_idle_run <= '0;
        end else if (r_idle_run != '1) begin
            r_idle_run <= r_idle_run + (ADDR_W + 1)'(1);
        end
    end

    // Pend legal delay writes; apply the pending delay once the idle gap is long enough.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_delay      <= INIT_D;
            r_pend_delay <= '0;
            r_pend       <= 1'b0;
        end else if (w_delay_ok) begin
            r_pend_delay <= delay_i;
            r_pend       <= 1'b1;
        end else if (w_apply) begin
            r_delay <= r_pend_delay;
            r_pend  <= 1'b0;
        end
    end

    // Select the egress word: bypass at zero delay, buffer otherwise, idle when link is down.
    always_comb begin
        // NOTE: assigning a default first keeps this block purely combinational (no latch).
        w_link_word = IDLE_WORD;
        if (link_up_i) begin
            if (r_delay == '0) begin
                w_link_word = w_in_word;
            end else begin
                w_link_word = r_mem[w_rd_addr];
            end
        end
    end

    // Count egress idle-to-non-idle transitions as seen after link forcing.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_cnt <= '0;
            r_prev_idle <= 1'b1;
        end else begin
            r_prev_idle <= w_out_idle;
            if (r_prev_idle && !w_out_idle) begin
                r_frame_cnt <= r_frame_cnt + 32'd1;
            end
        end
    end

`ifdef CHANNEL_ERR_INJ_EN
    logic r_err_inj_d;
    logic r_armed;
    logic w_inj_hit;

    // Corrupt the first all-data egress word after arming.
    assign w_inj_hit = r_armed && (w_link_word[WORD_W-1 -: CTRL_W] == '0);

    // Arm on a rising edge of err_inj_i; disarm on the cycle the flip happens.
    always_ff @(posedge clk) begin
        r_err_inj_d <= err_inj_i;
        if (rst || w_inj_hit) begin
            r_armed <= 1'b0;
        end else if (err_inj_i && !r_err_inj_d) begin
            r_armed <= 1'b1;
        end
    end

    assign bus.txd_o      = w_link_word[DATA_W-1:0] ^ {{(DATA_W-1){1'b0}}, w_inj_hit};
    assign err_inj_done_o = w_inj_hit;
`else
    logic w_unused_err_inj;

    assign w_unused_err_inj = err_inj_i;
    assign bus.txd_o        = w_link_word[DATA_W-1:0];
    assign err_inj_done_o   = 1'b0;
`endif

    assign bus.txc_o    = w_link_word[WORD_W-1 -: CTRL_W];
    assign delay_o      = r_delay;
    assign delay_pend_o = r_pend;
    assign frame_cnt_o  = r_frame_cnt;
endmodule

// File: tb/tb_xge_channel_emu.sv
// tb_xge_channel_emu: self-checking bench for xge_channel_emu, valid with or without
// CHANNEL_ERR_INJ_EN. Directed scenarios use hand-derived expectations; the random
// scenario uses a history-queue reference model of the channel.
module tb_xge_channel_emu;
    localparam int DW       = 64;
    localparam int CW       = 8;
    localparam int AW       = 6;
    localparam int MAXD     = 31;
    localparam int INITD    = 8;
    localparam int WW       = DW + CW;
    localparam int HIST_MAX = 140;
    localparam int RUN_SAT  = (1 << (AW + 1)) - 1;
    localparam logic [WW-1:0] IDLE  = {8'hFF, 64'h0707070707070707};
    localparam logic [WW-1:0] START = {8'h01, 64'hD5555555555555FB};
    localparam logic [WW-1:0] TERM  = {8'hFF, 64'h07070707070707FD};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          d_rst;
    logic [WW-1:0] d_word;
    logic          d_wr;
    logic [AW-1:0] d_dly;
    logic          d_link;
    logic          d_inj;

    logic [AW-1:0] delay_o;
    logic          delay_pend_o;
    logic [31:0]   frame_cnt_o;
    logic          err_inj_done_o;

    xge_channel_emu_if #(.DATA_W(DW), .CTRL_W(CW)) bus ();
    assign bus.rxd_i = d_word[DW-1:0];
    assign bus.rxc_i = d_word[WW-1:DW];

    xge_channel_emu #(
        .DATA_W(DW), .CTRL_W(CW), .ADDR_W(AW), .MAX_DELAY(MAXD), .INIT_DELAY(INITD)
    ) dut (
        .clk           (clk),
        .rst           (d_rst),
        .bus           (bus),
        .delay_i       (d_dly),
        .delay_wr_i    (d_wr),
        .delay_o       (delay_o),
        .delay_pend_o  (delay_pend_o),
        .link_up_i     (d_link),
        .frame_cnt_o   (frame_cnt_o),
        .err_inj_i     (d_inj),
        .err_inj_done_o(err_inj_done_o)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Observed DUT outputs for the last cycle.
    logic [WW-1:0] obs_word;
    logic [AW-1:0] obs_delay;
    logic          obs_pend;
    logic [31:0]   obs_frames;
    logic          obs_done;

    // Reference model state: ingress history since reset plus delay/injection bookkeeping.
    logic [WW-1:0] hist [$];
    int            m_delay    = INITD;
    int            m_pend_val = 0;
    bit            m_pend     = 1'b0;
    logic [31:0]   m_frames   = '0;
    bit            m_prev_idle = 1'b1;
    bit            m_armed    = 1'b0;
    bit            m_inj_prev = 1'b0;

    logic [WW-1:0] exp_word;
    logic [AW-1:0] exp_delay;
    logic          exp_pend;
    logic [31:0]   exp_frames;
    logic          exp_done;

    logic [WW-1:0] fr [16];

    function automatic int idle_run();
        int n = 0;
        for (int i = hist.size() - 1; i >= 0; i--) begin
            if (hist[i] != IDLE || n >= RUN_SAT) break;
            n++;
        end
        return n;
    endfunction

    function automatic logic [WW-1:0] rand_data();
        return {8'h00, $urandom, $urandom};
    endfunction

    task automatic make_frame(input int n);
        fr[0] = START;
        for (int i = 1; i < n - 1; i++) fr[i] = rand_data();
        fr[n-1] = TERM;
    endtask

    // Apply the driven inputs for one clock: sample DUT, compute model expectations, advance.
    task automatic cycle();
        logic [WW-1:0] base;
        int            run;
        int            need;
        @(negedge clk);
        obs_word   = {bus.txc_o, bus.txd_o};
        obs_delay  = delay_o;
        obs_pend   = delay_pend_o;
        obs_frames = frame_cnt_o;
        obs_done   = err_inj_done_o;

        if (!d_link) base = IDLE;
        else if (m_delay == 0) base = d_word;
        else if (hist.size() >= m_delay) base = hist[hist.size() - m_delay];
        else base = IDLE;
        exp_word = base;
        exp_done = 1'b0;
`ifdef CHANNEL_ERR_INJ_EN
        if (m_armed && base[WW-1:DW] == '0) begin
            exp_word[0] = ~base[0];
            exp_done    = 1'b1;
        end
`endif
        exp_delay  = AW'(m_delay);
        exp_pend   = m_pend;
        exp_frames = m_frames;

        if (d_rst) begin
            hist.delete();
            m_delay     = INITD;
            m_pend      = 1'b0;
            m_pend_val  = 0;
            m_frames    = '0;
            m_prev_idle = 1'b1;
            m_armed     = 1'b0;
            m_inj_prev  = d_inj;
        end else begin
            if (m_prev_idle && base != IDLE) m_frames = m_frames + 32'd1;
            m_prev_idle = (base == IDLE);
            run  = idle_run();
            need = (m_delay > m_pend_val) ? m_delay : m_pend_val;
            if (d_wr && int'(d_dly) <= MAXD) begin
                m_pend     = 1'b1;
                m_pend_val = int'(d_dly);
            end else if (m_pend && run >= need) begin
                m_delay = m_pend_val;
                m_pend  = 1'b0;
            end
            if (exp_done) m_armed = 1'b0;
            else if (d_inj && !m_inj_prev) m_armed = 1'b1;
            m_inj_prev = d_inj;
            hist.push_back(d_word);
            if (hist.size() > HIST_MAX) void'(hist.pop_front());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        d_rst = 1'b1; d_word = {8'h00, 64'hDEADBEEF01234567}; d_wr = 1'b0; d_link = 1'b1; d_inj = 1'b0;
        cycle();
        cycle();
        vectors++;
        if (obs_word !== IDLE) begin miscompares++; $display("FAIL rst_word got %h want %h", obs_word, IDLE); end
        vectors++;
        if (obs_delay !== AW'(INITD)) begin miscompares++; $display("FAIL rst_delay got %0d want %0d", obs_delay, INITD); end
        d_rst = 1'b0; d_word = IDLE;
        cycle();
        vectors++;
        if (obs_pend !== 1'b0) begin miscompares++; $display("FAIL rst_pend got %b want 0", obs_pend); end
        vectors++;
        if (obs_frames !== 32'd0) begin miscompares++; $display("FAIL rst_frames got %0d want 0", obs_frames); end
        vectors++;
        if (obs_done !== 1'b0) begin miscompares++; $display("FAIL rst_done got %b want 0", obs_done); end
    endtask

    task automatic test_latency();
        logic [WW-1:0] want;
        make_frame(10);
        for (int t = 0; t < 20; t++) begin
            d_word = (t < 10) ? fr[t] : IDLE;
            cycle();
            want = (t >= 8 && t < 18) ? fr[t-8] : IDLE;
            vectors++;
            if (obs_word !== want) begin miscompares++; $display("FAIL lat8_word t=%0d got %h want %h", t, obs_word, want); end
        end
        vectors++;
        if (obs_frames !== 32'd1) begin miscompares++; $display("FAIL lat8_frames got %0d want 1", obs_frames); end
    endtask

    task automatic test_delay_update();
        logic [WW-1:0] want;
        make_frame(10);
        d_dly = 6'd3;
        for (int t = 0; t < 10; t++) begin
            d_word = fr[t];
            d_wr   = (t == 3);
            cycle();
            if (t == 4) begin
                vectors++;
                if (obs_pend !== 1'b1) begin miscompares++; $display("FAIL upd_pend_set got %b want 1", obs_pend); end
                vectors++;
                if (obs_delay !== 6'd8) begin miscompares++; $display("FAIL upd_delay_hold got %0d want 8", obs_delay); end
            end
        end
        d_wr = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            d_word = IDLE;
            cycle();
            vectors++;
            if (obs_delay !== ((k >= 10) ? 6'd3 : 6'd8)) begin
                miscompares++; $display("FAIL upd_delay k=%0d got %0d want %0d", k, obs_delay, (k >= 10) ? 3 : 8);
            end
            vectors++;
            if (obs_pend !== (k < 10)) begin miscompares++; $display("FAIL upd_pend k=%0d got %b want %b", k, obs_pend, k < 10); end
        end
        make_frame(10);
        for (int t = 0; t < 15; t++) begin
            d_word = (t < 10) ? fr[t] : IDLE;
            cycle();
            want = (t >= 3 && t < 13) ? fr[t-3] : IDLE;
            vectors++;
            if (obs_word !== want) begin miscompares++; $display("FAIL lat3_word t=%0d got %h want %h", t, obs_word, want); end
        end
    endtask

    task automatic test_back_to_back();
        d_word = IDLE;
        repeat (40) cycle();
        d_wr = 1'b1; d_dly = 6'd31;
        cycle();
        d_dly = 6'd0;
        cycle();
        d_wr = 1'b0;
        vectors++;
        if (obs_delay !== 6'd3) begin miscompares++; $display("FAIL b2b_no31 got %0d want 3", obs_delay); end
        cycle();
        vectors++;
        if (obs_delay !== 6'd3 || obs_pend !== 1'b1) begin
            miscompares++; $display("FAIL b2b_pending got delay %0d pend %b want 3 1", obs_delay, obs_pend);
        end
        cycle();
        vectors++;
        if (obs_delay !== 6'd0 || obs_pend !== 1'b0) begin
            miscompares++; $display("FAIL b2b_applied got delay %0d pend %b want 0 0", obs_delay, obs_pend);
        end
        make_frame(10);
        for (int t = 0; t < 12; t++) begin
            d_word = (t < 10) ? fr[t] : IDLE;
            cycle();
            vectors++;
            if (obs_word !== d_word) begin miscompares++; $display("FAIL lat0_word t=%0d got %h want %h", t, obs_word, d_word); end
        end
    endtask

    task automatic test_invalid_delay();
        d_word = IDLE; d_wr = 1'b1; d_dly = 6'd40;
        cycle();
        d_wr = 1'b0;
        cycle();
        vectors++;
        if (obs_delay !== 6'd0 || obs_pend !== 1'b0) begin
            miscompares++; $display("FAIL inv_ignored got delay %0d pend %b want 0 0", obs_delay, obs_pend);
        end
        make_frame(10);
        for (int t = 0; t < 10; t++) begin
            d_word = fr[t];
            d_wr   = (t == 2) || (t == 4);
            d_dly  = (t == 2) ? 6'd5 : 6'd40;
            cycle();
            if (t == 5) begin
                vectors++;
                if (obs_delay !== 6'd0 || obs_pend !== 1'b1) begin
                    miscompares++; $display("FAIL inv_keep_pend got delay %0d pend %b want 0 1", obs_delay, obs_pend);
                end
            end
        end
        d_wr = 1'b0; d_word = IDLE;
        repeat (10) cycle();
        vectors++;
        if (obs_delay !== 6'd5 || obs_pend !== 1'b0) begin
            miscompares++; $display("FAIL inv_final got delay %0d pend %b want 5 0", obs_delay, obs_pend);
        end
    endtask

    task automatic test_link_down();
        logic [31:0]   base_cnt;
        logic [WW-1:0] want;
        d_word = IDLE;
        cycle();
        base_cnt = obs_frames;
        make_frame(12);
        for (int t = 0; t < 20; t++) begin
            d_word = (t < 12) ? fr[t] : IDLE;
            d_link = !(t >= 8 && t < 13);
            cycle();
            want = (!d_link) ? IDLE : ((t >= 5 && t < 17) ? fr[t-5] : IDLE);
            vectors++;
            if (obs_word !== want) begin miscompares++; $display("FAIL link_word t=%0d got %h want %h", t, obs_word, want); end
        end
        d_link = 1'b1;
        vectors++;
        if (obs_frames !== base_cnt + 32'd2) begin
            miscompares++; $display("FAIL link_frames got %0d want %0d", obs_frames, base_cnt + 32'd2);
        end
    endtask

    task automatic test_reset_mid_frame();
        make_frame(10);
        for (int t = 0; t < 8; t++) begin
            d_word = fr[t];
            cycle();
        end
        d_rst = 1'b1; d_word = fr[8];
        cycle();
        d_rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            d_word = IDLE;
            cycle();
            vectors++;
            if (obs_word !== IDLE) begin miscompares++; $display("FAIL midrst_word k=%0d got %h want %h", k, obs_word, IDLE); end
            if (k == 0) begin
                vectors++;
                if (obs_frames !== 32'd0 || obs_delay !== AW'(INITD) || obs_pend !== 1'b0 || obs_done !== 1'b0) begin
                    miscompares++;
                    $display("FAIL midrst_state got frames %0d delay %0d pend %b done %b want 0 %0d 0 0", obs_frames, obs_delay, obs_pend, obs_done, INITD);
                end
            end
        end
    endtask

    task automatic test_err_inj();
        logic [WW-1:0] want;
        logic          want_done;
        int            done_cnt = 0;
        d_word = IDLE;
        d_inj = 1'b1; cycle();
        d_inj = 1'b0; cycle();
        d_inj = 1'b1; cycle();
        d_inj = 1'b0;
        make_frame(10);
        fr[1] = {8'h00, 64'h0000000000000000};
        for (int t = 0; t < 20; t++) begin
            d_word = (t < 10) ? fr[t] : IDLE;
            cycle();
            want      = (t >= 8 && t < 18) ? fr[t-8] : IDLE;
            want_done = 1'b0;
`ifdef CHANNEL_ERR_INJ_EN
            if (t == 9) begin
                want      = {8'h00, 64'h0000000000000001};
                want_done = 1'b1;
            end
`endif
            if (obs_done === 1'b1) done_cnt++;
            vectors++;
            if (obs_word !== want) begin miscompares++; $display("FAIL inj_word t=%0d got %h want %h", t, obs_word, want); end
            vectors++;
            if (obs_done !== want_done) begin miscompares++; $display("FAIL inj_done t=%0d got %b want %b", t, obs_done, want_done); end
        end
        vectors++;
`ifdef CHANNEL_ERR_INJ_EN
        if (done_cnt != 1) begin miscompares++; $display("FAIL inj_pulses got %0d want 1", done_cnt); end
`else
        if (done_cnt != 0) begin miscompares++; $display("FAIL inj_pulses got %0d want 0", done_cnt); end
`endif
    endtask

    task automatic test_random();
        int rem     = 0;
        int gap     = 0;
        int link_lo = 0;
        d_rst = 1'b1; d_word = IDLE; d_wr = 1'b0; d_link = 1'b1; d_inj = 1'b0;
        cycle();
        d_rst = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (rem > 0) begin
                rem--;
                if (rem == 0) d_word = TERM;
                else if ($urandom_range(0, 9) == 0) d_word = {8'($urandom_range(0, 255)), $urandom, $urandom};
                else d_word = rand_data();
            end else if (gap > 0) begin
                gap--;
                d_word = IDLE;
            end else begin
                d_word = START;
                rem    = $urandom_range(2, 14);
                gap    = $urandom_range(0, 40);
            end
            if (link_lo > 0) begin
                link_lo--;
                d_link = 1'b0;
            end else begin
                d_link = 1'b1;
                if ($urandom_range(0, 99) == 0) link_lo = $urandom_range(1, 6);
            end
            d_wr  = ($urandom_range(0, 19) == 0);
            d_dly = AW'($urandom_range(0, 45));
            d_inj = ($urandom_range(0, 29) == 0);
            d_rst = ($urandom_range(0, 499) == 0);
            cycle();
            vectors++;
            if (obs_word !== exp_word) begin miscompares++; $display("FAIL rnd_word n=%0d got %h want %h", n, obs_word, exp_word); end
            vectors++;
            if (obs_done !== exp_done) begin miscompares++; $display("FAIL rnd_done n=%0d got %b want %b", n, obs_done, exp_done); end
            vectors++;
            if (obs_delay !== exp_delay) begin miscompares++; $display("FAIL rnd_delay n=%0d got %0d want %0d", n, obs_delay, exp_delay); end
            vectors++;
            if (obs_pend !== exp_pend) begin miscompares++; $display("FAIL rnd_pend n=%0d got %b want %b", n, obs_pend, exp_pend); end
            vectors++;
            if (obs_frames !== exp_frames) begin miscompares++; $display("FAIL rnd_frames n=%0d got %0d want %0d", n, obs_frames, exp_frames); end
        end
        d_rst = 1'b0; d_wr = 1'b0; d_inj = 1'b0; d_link = 1'b1;
    endtask

    initial begin
        d_rst = 1'b1; d_word = IDLE; d_wr = 1'b0; d_dly = '0; d_link = 1'b1; d_inj = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_latency();
        test_delay_update();
        test_back_to_back();
        test_invalid_delay();
        test_link_down();
        test_reset_mid_frame();
        test_err_inj();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/xge_channel_emu.md
Name: xge_channel_emu

Overview:
- Parametrised successor to the testbench fixed-delay channel model.
- Emulates one direction of a PHY-side link between two PTP endpoints: the MAC-side word stream (XGMII 64/8 or GMII-style 8/2) is delayed by a delay that can be changed at run time.
- Delay updates take effect only across a guaranteed idle gap, so frames are never split or duplicated.
- Also provides link-down forcing, output frame counting and optional error injection.
- Used in pairs, one per direction, to build asymmetric-path PTP scenarios.

Parameters:
- DATA_W, 64, data bus width.
- CTRL_W, 8, control bus width. Use 8 for XGMII, 2 for {en,er} GMII.
- ADDR_W, 5, buffer address width. Buffer depth = 2^ADDR_W.
- MAX_DELAY, 31, largest legal delay in cycles. Must be ≤ 2^ADDR_W − 1.
- INIT_DELAY, 8, active delay after reset.
- IDLE_D, 64'h0707070707070707, idle data pattern, truncated to DATA_W.
- IDLE_C, 8'hFF, idle control pattern, truncated to CTRL_W.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  synchronous, active-high reset.
- rxd_i  in  DATA_W  ingress data.
- rxc_i  in  CTRL_W  ingress control.
- txd_o  out  DATA_W  egress data.
- txc_o  out  CTRL_W  egress control.
- delay_i  in  ADDR_W  requested delay in cycles.
- delay_wr_i  in  1  one-cycle strobe; captures delay_i as the pending delay.
- delay_o  out  ADDR_W  currently active delay.
- delay_pend_o  out  1  a pending delay is waiting to be applied.
- link_up_i  in  1  0 forces idle on the output.
- frame_cnt_o  out  32  count of frames leaving the block.
- err_inj_i  in  1  arm error injection (see Optional Feature).
- err_inj_done_o  out  1  injection performed.

Behaviour:
- Idle word: {rxc,rxd} == {IDLE_C,IDLE_D}. Any other value is non-idle.
- Storage: circular buffer of 2^ADDR_W entries.
  - Each cycle, {rxc_i,rxd_i} is written at wr_ptr, then wr_ptr increments (wraps modulo depth).
  - Read address = wr_ptr − delay_o, modulo depth.
  - Output for active delay D equals the input from exactly D cycles earlier.
  - D = 0 is a combinational bypass (out = in).
- Reset, synchronous on rst = 1:
  - Every buffer entry is set to the idle word; wr_ptr = 0.
  - delay_o = INIT_DELAY; delay_pend_o = 0; frame_cnt_o = 0; err_inj_done_o = 0; idle_run = 0.
  - txd_o/txc_o show the idle word from the cycle after reset is asserted.
  - Reset mid-frame truncates the frame. No partial frame is emitted after reset.
- Delay update:
  - delay_wr_i with delay_i ≤ MAX_DELAY loads pending_delay and sets delay_pend_o.
  - Values > MAX_DELAY are ignored; pending state is unchanged.
  - A second write before apply overwrites pending_delay.
  - idle_run: saturating counter of consecutive idle input words, width ADDR_W+1. Cleared on any non-idle input.
  - Apply rule: in a cycle with delay_pend_o = 1 and idle_run ≥ max(delay_o, pending_delay), set delay_o ← pending_delay and clear delay_pend_o. The new delay is effective from the next cycle.
  - If delay_wr_i and the apply condition coincide, the write wins: the new value is pended and nothing is applied that cycle.
  - A delay change only drops or repeats idle words.
- Link down:
  - While link_up_i = 0, txd_o/txc_o = idle word, combinationally. The buffer keeps filling.
  - On return to 1, output resumes from the buffer at the next word boundary.
  - A frame in flight is truncated. The emulator does not repair truncated frames.
- Frame count:
  - frame_cnt_o increments on each egress idle→non-idle transition, measured after link forcing.
  - Wraps from 2^32−1 to 0.

Optional Feature:
- Macro: CHANNEL_ERR_INJ_EN.
- Defined:
  - A rising edge on err_inj_i arms one injection.
  - The next egress word with txc_o == 0 (all data lanes) has txd_o[0] inverted.
  - err_inj_done_o pulses high for exactly that cycle, then injection disarms.
  - Re-arming while already armed has no effect.
  - Reset disarms.
- Undefined: err_inj_i is ignored, err_inj_done_o is tied to 0, and the data path is untouched.

Test Plan:
- Reset, then a 10-word frame (start, 8 data words, terminate) with INIT_DELAY = 8 → identical words appear on txd_o/txc_o exactly 8 cycles later; frame_cnt_o = 1.
- delay_wr_i with delay_i = 3 during a frame, followed by 8 idle cycles → delay_o stays 8 until idle_run reaches 8, then becomes 3; the next frame has latency 3 with no dropped or duplicated data words.
- delay_i = 31, then delay_i = 0 back-to-back, with continuous idle → only 0 is applied; frame latency is 0 (combinational); delay_pend_o clears.
- delay_wr_i with delay_i = 40 while MAX_DELAY = 31 → ignored; delay_o and delay_pend_o are unchanged.
- link_up_i low for 5 cycles mid-frame → output is idle during those 5 cycles; frame_cnt_o increments once more when the truncated tail resumes. Assert rst mid-frame → idle output and all counters 0 the next cycle.
- With CHANNEL_ERR_INJ_EN, pulse err_inj_i, then send a frame with data word 64'h0000000000000000 → egress word = 64'h0000000000000001 and err_inj_done_o is a 1-cycle pulse. Without the macro → data is unchanged and err_inj_done_o stays 0.
